// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream channel carrying an opaque payload plus a control bundle
// between two pipeline stages. The producer uses master, the consumer uses slave.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and a
// saturating bubble counter. Define PIPE_SKID_EN for the 2-entry skid variant.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_reg_if.slave   in_if,
    pipe_stage_reg_if.master  out_if,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              in_fire;
    logic              main_free;

    assign in_fire   = in_if.valid & in_if.ready;
    assign main_free = ~valid_q | out_if.ready;

    always_comb begin
        cnt_d = cnt_q;
        if (out_if.ready && !valid_q)
            cnt_d = sat_inc(cnt_q);
    end

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // Ready depends only on the skid flag, so out_ready never reaches in_ready.
    assign in_if.ready = ~skid_valid_q;
    assign occupancy   = {1'b0, valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        ctrl_d       = ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // in_fire is impossible here: in_ready is low while skid is full.
                valid_d      = 1'b1;
                data_d       = skid_data_q;
                ctrl_d       = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                valid_d = 1'b1;
                data_d  = in_if.data;
                ctrl_d  = in_if.ctrl;
            end else begin
                valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_if.data;
            skid_ctrl_d  = in_if.ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
`else
    assign in_if.ready = main_free;
    assign occupancy   = {1'b0, valid_q};

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d = 1'b1;
            data_d  = in_if.data;
            ctrl_d  = in_if.ctrl;
        end else if (out_if.ready) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bubbles always present a NOP control word downstream.
    assign out_if.valid = valid_q;
    assign out_if.data  = data_q;
    assign out_if.ctrl  = valid_q ? ctrl_q : '0;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus randomized bench for pipe_stage_reg; reference model is a
// bounded queue of entries checked every cycle against the DUT outputs.
module tb_pipe_stage_reg;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) in_if ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) out_if ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_if      (in_if),
        .out_if     (out_if),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    entry_t            mq[$];
    logic [DATA_W-1:0] m_last;
    int                m_cnt;
    int                n_vec = 0;
    int                n_err = 0;
    bit                last_fire;
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] src[$];

    function automatic bit m_in_ready();
        if (CAP == 1) return (mq.size() == 0) || out_if.ready;
        return mq.size() < 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_if.valid), 64'(mq.size() > 0));
        check({tag, ".out_ctrl"},  64'(out_if.ctrl),  (mq.size() > 0) ? 64'(mq[0].ctrl) : 64'd0);
        check({tag, ".out_data"},  64'(out_if.data),  64'(m_last));
        check({tag, ".in_ready"},  64'(in_if.ready),  64'(m_in_ready()));
        check({tag, ".occupancy"}, 64'(occupancy),    64'(mq.size()));
        check({tag, ".bubble_cnt"},64'(bubble_cnt),   64'(m_cnt));
    endtask

    // One clock: check outputs, advance the model across the edge.
    task automatic cycle(input string tag);
        bit fin, fout;
        entry_t e;
        #1;
        check_all(tag);
        fin  = in_if.valid && m_in_ready();
        fout = (mq.size() > 0) && out_if.ready;
        if (out_if.valid && out_if.ready) got.push_back(out_if.data);
        e.data = in_if.data;
        e.ctrl = in_if.ctrl;
        @(posedge clk);
        if (out_if.ready && mq.size() == 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (flush) begin
            mq.delete();
            fin = 1'b0;
        end else begin
            if (fout) void'(mq.pop_front());
            if (fin) mq.push_back(e);
        end
        if (mq.size() > 0) m_last = mq[0].data;
        last_fire = fin;
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        mq.delete();
        m_last = '0;
        m_cnt  = 0;
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive_src(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            in_if.valid = (src.size() > 0);
            in_if.data  = (src.size() > 0) ? src[0] : '0;
            in_if.ctrl  = (src.size() > 0) ? CTRL_W'(src[0]) : '0;
            cycle(tag);
            if (last_fire) void'(src.pop_front());
        end
        in_if.valid = 1'b0;
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.ctrl   = '0;
        out_if.ready = 1'b0;
        do_reset("init");

        // Reset while an entry is still held
        in_if.valid = 1'b1; in_if.data = 32'hA5; in_if.ctrl = 16'h00FF;
        cycle("push_a5");
        in_if.valid = 1'b0;
        #1;
        check("pre_rst_valid", 64'(out_if.valid), 64'd1);
        do_reset("rst_mid");
        check("rst_out_data", 64'(out_if.data), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);

        // Streaming
        out_if.ready = 1'b1;
        got.delete();
        for (int i = 1; i <= 8; i++) begin
            in_if.valid = 1'b1; in_if.data = DATA_W'(i); in_if.ctrl = CTRL_W'(i);
            cycle("stream");
            check("stream_accept", 64'(last_fire), 64'd1);
        end
        in_if.valid = 1'b0;
        cycle("stream_tail");
        cycle("stream_tail");
        check("stream_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < got.size(); i++) check("stream_order", 64'(got[i]), 64'(i + 1));

        // Backpressure
        out_if.ready = 1'b0;
        got.delete();
        src = '{32'd1, 32'd2, 32'd3};
        drive_src(5, "bp_hold");
        check("bp_accepted", 64'(3 - src.size()), 64'(CAP));
        check("bp_in_ready", 64'(in_if.ready), 64'd0);
        out_if.ready = 1'b1;
        drive_src(8, "bp_release");
        check("bp_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < got.size(); i++) check("bp_order", 64'(got[i]), 64'(i + 1));

        // Flush with a concurrent push
        out_if.ready = 1'b0;
        src = '{32'h11, 32'h12};
        drive_src(3, "fl_fill");
        check("fl_full", 64'(occupancy), 64'(CAP));
        flush = 1'b1; in_if.valid = 1'b1; in_if.data = 32'd9; in_if.ctrl = 16'h0009;
        cycle("fl_edge");
        flush = 1'b0; in_if.valid = 1'b0;
        #1;
        check("fl_valid", 64'(out_if.valid), 64'd0);
        check("fl_ctrl", 64'(out_if.ctrl), 64'd0);
        check("fl_occ", 64'(occupancy), 64'd0);
        got.delete();
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle("fl_after");
        check("fl_no9", 64'(got.size()), 64'd0);

        // Bubble counter saturation
        do_reset("bc_rst");
        out_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("bc_stall");
        check("bc_no_inc", 64'(bubble_cnt), 64'd0);
        out_if.ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle("bc_idle");
        check("bc_sat", 64'(bubble_cnt), 64'd15);
        out_if.ready = 1'b0;
        for (int i = 0; i < 2; i++) cycle("bc_hold");
        check("bc_hold", 64'(bubble_cnt), 64'd15);

        // Control gating on a bubble
        out_if.ready = 1'b1;
        in_if.valid = 1'b1; in_if.data = 32'h77; in_if.ctrl = 16'hFFFF;
        cycle("cg_push");
        #1;
        check("cg_ctrl_live", 64'(out_if.ctrl), 64'hFFFF);
        in_if.valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle("cg_idle");
        check("cg_ctrl0", 64'(out_if.ctrl), 64'd0);
        check("cg_data", 64'(out_if.data), 64'h77);

        // Randomized traffic
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            in_if.valid  = ($urandom_range(0, 3) != 0);
            in_if.data   = $urandom;
            in_if.ctrl   = CTRL_W'($urandom);
            out_if.ready = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            cycle("rnd");
        end
        flush = 1'b0;
        in_if.valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
